// File: rtl/tdc_pkg.sv
// ---------------------------------------------------------------------------
// tdc_pkg
// Shared types and helpers for the TDC thermometer decoder slice.
//   fsm_state_e  : window FSM states (ACCUM collects codes, HOLD presents a result)
//   code_w_for() : binary code width needed for a given tap count
//   maj3()       : 2-of-3 majority used for single-bit bubble removal
//   result_t     : one published result word (average, min, max, flags)
// ---------------------------------------------------------------------------
package tdc_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } fsm_state_e;

  // Width of a tap count 0..n_delay.
  function automatic int code_w_for(input int n_delay);
    return $clog2(n_delay + 1);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // The result word is sized for the production 32-tap delay line; a longer
  // line needs RES_N_DELAY raised so the code fields can hold the tap count.
  localparam int RES_N_DELAY = 32;
  localparam int RES_CODE_W  = code_w_for(RES_N_DELAY);

  typedef struct packed {
    logic [RES_CODE_W-1:0] code;
    logic [RES_CODE_W-1:0] min;
    logic [RES_CODE_W-1:0] max;
    logic                  bubble;
    logic                  sat;
    logic                  overrun;
  } result_t;

endpackage

// File: rtl/tdc_bubble_popcount.sv
// ---------------------------------------------------------------------------
// tdc_bubble_popcount
// Purely combinational thermometer helper.
//   therm_i  [N_DELAY] : raw thermometer word, ones fill from bit 0 upward
//   corr_o   [N_DELAY] : bubble-corrected word, c[i] = maj(t[i-1], t[i], t[i+1])
//                        with t[-1] = 1 and t[N_DELAY] = 0
//   bubble_o           : correction changed at least one bit
//   sat_o              : raw word is all ones (edge beyond the line)
//   pop_i    [N_DELAY] : word to count
//   code_o   [CODE_W]  : number of ones in pop_i
// The popcount takes its own input so a caller can put a register stage
// between correction and counting.
// ---------------------------------------------------------------------------
module tdc_bubble_popcount
  import tdc_pkg::*;
#(
  parameter int N_DELAY = 32,
  parameter int CODE_W  = 6
) (
  input  logic [N_DELAY-1:0] therm_i,
  output logic [N_DELAY-1:0] corr_o,
  output logic               bubble_o,
  output logic               sat_o,
  input  logic [N_DELAY-1:0] pop_i,
  output logic [CODE_W-1:0]  code_o
);

  // Pad the word with the virtual neighbours: a one below bit 0, a zero above the top tap.
  logic [N_DELAY+1:0] ext_s;
  assign ext_s = {1'b0, therm_i, 1'b1};

  // Majority of each tap with its two neighbours.
  always_comb begin
    corr_o = '0;
    for (int i = 0; i < N_DELAY; i++) begin
      corr_o[i] = maj3(ext_s[i], ext_s[i+1], ext_s[i+2]);
    end
  end

  assign bubble_o = (corr_o != therm_i);
  assign sat_o    = &therm_i;

  // Population count of the corrected word.
  always_comb begin
    code_o = '0;
    for (int i = 0; i < N_DELAY; i++) begin
      code_o = code_o + CODE_W'(pop_i[i]);
    end
  end

endmodule

// File: rtl/tdc_therm_decoder.sv
// ---------------------------------------------------------------------------
// tdc_therm_decoder
// Decodes tapped-delay-line thermometer samples into binary tap counts and
// publishes one averaged result per window of 2^AVG_LOG2 samples.
//   clk, rst_n    : clock; reset is asynchronous and active-HIGH (rst_n = 1 resets)
//   sample_valid  : sample presented this cycle (always accepted)
//   sample        : thermometer word [N_DELAY]
//   out_valid     : result word available (held until out_ready)
//   out_ready     : consumer accepts the result
//   out_code      : window average, truncated
//   out_min/max   : minimum / maximum code seen in the window
//   out_bubble    : some sample in the window needed bubble correction
//   out_sat       : some sample in the window was all ones
//   out_overrun   : codes were dropped while the previous result was held
// Pipeline: stage 1 registers the corrected word and flags, stage 2 registers
// the popcount, and the window FSM consumes stage 2 one edge later.
// ---------------------------------------------------------------------------
module tdc_therm_decoder
  import tdc_pkg::*;
#(
  parameter int N_DELAY  = 32,
  parameter int CODE_W   = code_w_for(N_DELAY),
  parameter int AVG_LOG2 = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_valid,
  input  logic [N_DELAY-1:0] sample,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CODE_W-1:0]  out_code,
  output logic [CODE_W-1:0]  out_min,
  output logic [CODE_W-1:0]  out_max,
  output logic               out_bubble,
  output logic               out_sat,
  output logic               out_overrun
);

  // The sum of 2^AVG_LOG2 codes of at most N_DELAY each fits in ACC_W bits.
  localparam int ACC_W = CODE_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  // ---------------- correction / popcount ----------------
  logic [N_DELAY-1:0] corr_s;
  logic               bubble_s;
  logic               sat_s;
  logic [CODE_W-1:0]  code_s;

  logic               s1_valid_q;
  logic [N_DELAY-1:0] s1_corr_q;
  logic               s1_bubble_q;
  logic               s1_sat_q;

  logic               s2_valid_q;
  logic [CODE_W-1:0]  s2_code_q;
  logic               s2_bubble_q;
  logic               s2_sat_q;

  tdc_bubble_popcount #(
    .N_DELAY (N_DELAY),
    .CODE_W  (CODE_W)
  ) u_bubble_popcount (
    .therm_i  (sample),
    .corr_o   (corr_s),
    .bubble_o (bubble_s),
    .sat_o    (sat_s),
    .pop_i    (s1_corr_q),
    .code_o   (code_s)
  );

  // Stage 1: capture the corrected word and its flags.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_corr_q   <= '0;
      s1_bubble_q <= 1'b0;
      s1_sat_q    <= 1'b0;
    end else begin
      s1_valid_q <= sample_valid;
      if (sample_valid) begin
        s1_corr_q   <= corr_s;
        s1_bubble_q <= bubble_s;
        s1_sat_q    <= sat_s;
      end
    end
  end

  // Stage 2: capture the tap count with the flags carried alongside.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_code_q   <= '0;
      s2_bubble_q <= 1'b0;
      s2_sat_q    <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_code_q   <= code_s;
        s2_bubble_q <= s1_bubble_q;
        s2_sat_q    <= s1_sat_q;
      end
    end
  end

  // ---------------- window FSM ----------------
  fsm_state_e        state_q,     state_d;
  logic [ACC_W-1:0]  acc_q,       acc_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [CODE_W-1:0] min_q,       min_d;
  logic [CODE_W-1:0] max_q,       max_d;
  logic              bub_q,       bub_d;
  logic              sat_q,       sat_d;
  logic              pend_q,      pend_d;
  logic              out_valid_q, out_valid_d;
  result_t           res_q,       res_d;

  logic [ACC_W-1:0]  sum_s;
  logic [CODE_W-1:0] new_min_s;
  logic [CODE_W-1:0] new_max_s;
  logic              accept_s;
  logic              step_s;
  logic              drop_s;

  assign sum_s     = acc_q + ACC_W'(s2_code_q);
  // Strict compares: a tie keeps the register as it is.
  assign new_min_s = (s2_code_q < min_q) ? s2_code_q : min_q;
  assign new_max_s = (s2_code_q > max_q) ? s2_code_q : max_q;
  assign accept_s  = out_valid_q & out_ready;

  // Next-state logic: accumulate, publish, hold, and hand over to a new window.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    min_d       = min_q;
    max_d       = max_q;
    bub_d       = bub_q;
    sat_d       = sat_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    step_s      = 1'b0;
    drop_s      = 1'b0;

    case (state_q)
      ACCUM: begin
        step_s = s2_valid_q;
      end
      HOLD: begin
        if (accept_s) begin
          // A code arriving with the handshake opens the next window.
          state_d     = ACCUM;
          out_valid_d = 1'b0;
          step_s      = s2_valid_q;
        end else begin
          drop_s = s2_valid_q;
        end
      end
      default: begin
        state_d     = ACCUM;
        out_valid_d = 1'b0;
      end
    endcase

    if (drop_s) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_d;
    end

    // Window state is cleared as the result is registered, so HOLD always
    // sees an empty window and a code taken at handshake becomes sample one.
    if (step_s) begin
      if (cnt_q == WIN_LAST) begin
        res_d.code    = RES_CODE_W'(sum_s >> AVG_LOG2);
        res_d.min     = RES_CODE_W'(new_min_s);
        res_d.max     = RES_CODE_W'(new_max_s);
        res_d.bubble  = bub_q | s2_bubble_q;
        res_d.sat     = sat_q | s2_sat_q;
        res_d.overrun = pend_q;
        pend_d        = 1'b0;
        acc_d         = '0;
        cnt_d         = '0;
        min_d         = '1;
        max_d         = '0;
        bub_d         = 1'b0;
        sat_d         = 1'b0;
        state_d       = HOLD;
        out_valid_d   = 1'b1;
      end else begin
        acc_d = sum_s;
        cnt_d = cnt_q + CNT_W'(1);
        min_d = new_min_s;
        max_d = new_max_s;
        bub_d = bub_q | s2_bubble_q;
        sat_d = sat_q | s2_sat_q;
      end
    end else begin
      acc_d = acc_d;
    end
  end

  // Window state and result registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      min_q       <= '1;
      max_q       <= '0;
      bub_q       <= 1'b0;
      sat_q       <= 1'b0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      min_q       <= min_d;
      max_q       <= max_d;
      bub_q       <= bub_d;
      sat_q       <= sat_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_code    = CODE_W'(res_q.code);
  assign out_min     = CODE_W'(res_q.min);
  assign out_max     = CODE_W'(res_q.max);
  assign out_bubble  = res_q.bubble;
  assign out_sat     = res_q.sat;
  assign out_overrun = res_q.overrun;

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// ---------------------------------------------------------------------------
// tb_tdc_therm_decoder
// Scoreboard bench: a reference model computes each window's result as
// samples are sent; a monitor records every accepted result; each test task
// pops and compares.
// ---------------------------------------------------------------------------
module tb_tdc_therm_decoder;

  localparam int N   = 32;
  localparam int CW  = 6;
  localparam int AVG = 2;
  localparam int WIN = 1 << AVG;

  logic          clk          = 1'b0;
  logic          rst_n        = 1'b1;
  logic          sample_valid = 1'b0;
  logic [N-1:0]  sample       = '0;
  logic          out_ready    = 1'b0;
  logic          out_valid;
  logic [CW-1:0] out_code;
  logic [CW-1:0] out_min;
  logic [CW-1:0] out_max;
  logic          out_bubble;
  logic          out_sat;
  logic          out_overrun;

  typedef struct packed {
    logic [CW-1:0] code;
    logic [CW-1:0] mn;
    logic [CW-1:0] mx;
    logic          bub;
    logic          sat;
    logic          ovr;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int m_cnt, m_sum, m_min, m_max;
  bit m_bub, m_sat, m_pend;

  tdc_therm_decoder #(
    .N_DELAY  (N),
    .CODE_W   (CW),
    .AVG_LOG2 (AVG)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_code     (out_code),
    .out_min      (out_min),
    .out_max      (out_max),
    .out_bubble   (out_bubble),
    .out_sat      (out_sat),
    .out_overrun  (out_overrun)
  );

  always #5 clk = ~clk;

  // Record each result at the handshake (sampled mid-cycle).
  always @(negedge clk) begin
    if (rst_n === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1)
      obs_q.push_back({out_code, out_min, out_max, out_bubble, out_sat, out_overrun});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model_clear();
    m_cnt = 0; m_sum = 0; m_min = 1000; m_max = -1; m_bub = 1'b0; m_sat = 1'b0;
  endfunction

  function automatic void model_take(input logic [N-1:0] t);
    logic [N+1:0] ext;
    logic [N-1:0] c;
    int code;
    ext = {1'b0, t, 1'b1};
    for (int i = 0; i < N; i++)
      c[i] = ((int'(ext[i]) + int'(ext[i+1]) + int'(ext[i+2])) >= 2);
    code = $countones(c);
    m_sum += code;
    if (code < m_min) m_min = code;
    if (code > m_max) m_max = code;
    m_bub |= (c != t);
    m_sat |= (t == {N{1'b1}});
    m_cnt++;
    if (m_cnt == WIN) begin
      exp_q.push_back({CW'(m_sum >> AVG), CW'(m_min), CW'(m_max), m_bub, m_sat, m_pend});
      m_pend = 1'b0;
      model_clear();
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  // One sample per call; entered and left just after a rising edge.
  task automatic send(input logic [N-1:0] t, input bit counted);
    sample       = t;
    sample_valid = 1'b1;
    if (counted) model_take(t);
    else         m_pend = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  // Waits (bounded) for a recorded result and pops it with its expectation.
  task automatic take_result(output res_t o, output res_t e, output bit ok);
    int n = 0;
    o = '0;
    e = '0;
    while (obs_q.size() == 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = (obs_q.size() > 0) && (exp_q.size() > 0);
    if (ok) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if ({out_code, out_min, out_max} !== '0)
      $display("FAIL reset_codes: got code=%0d min=%0d max=%0d want 0/0/0", out_code, out_min, out_max);
    else n_pass++;
    n_checks++;
    if ({out_bubble, out_sat, out_overrun} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {out_bubble, out_sat, out_overrun});
    else n_pass++;
    rst_n = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_defaults();
    res_t o, e;
    bit   ok;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(32'h0000_00FF, 1'b1);
    // out_valid rises two edges after the 4th sample and lasts one cycle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== (i == 2)) $display("FAIL latency_cycle%0d: got %0b want %0b", i, out_valid, (i == 2));
      else n_pass++;
    end
    take_result(o, e, ok);
    n_checks++;
    if (!ok) $display("FAIL defaults_result: no result within budget");
    else if (o !== e)
      $display("FAIL defaults_result: got code=%0d min=%0d max=%0d b=%0b s=%0b o=%0b want code=%0d min=%0d max=%0d b=%0b s=%0b o=%0b",
               o.code, o.mn, o.mx, o.bub, o.sat, o.ovr, e.code, e.mn, e.mx, e.bub, e.sat, e.ovr);
    else n_pass++;
  endtask

  task automatic test_ramp();
    res_t o, e;
    bit   ok;
    send(32'h0000_000F, 1'b1);
    send(32'h0000_001F, 1'b1);
    send(32'h0000_003F, 1'b1);
    send(32'h0000_007F, 1'b1);
    take_result(o, e, ok);
    n_checks++;
    if (!ok) $display("FAIL ramp_result: no result within budget");
    else if (o !== e)
      $display("FAIL ramp_result: got code=%0d min=%0d max=%0d b=%0b s=%0b o=%0b want code=%0d min=%0d max=%0d b=%0b s=%0b o=%0b",
               o.code, o.mn, o.mx, o.bub, o.sat, o.ovr, e.code, e.mn, e.mx, e.bub, e.sat, e.ovr);
    else n_pass++;
  endtask

  // Bubble window followed back-to-back by a saturated window.
  task automatic test_back_to_back_flags();
    res_t o, e;
    bit   ok;
    send(32'h0000_00FB, 1'b1);
    for (int i = 0; i < 3; i++) send(32'h0000_00FF, 1'b1);
    for (int i = 0; i < 4; i++) send(32'hFFFF_FFFF, 1'b1);
    for (int r = 0; r < 2; r++) begin
      take_result(o, e, ok);
      n_checks++;
      if (!ok) $display("FAIL flags_result%0d: no result within budget", r);
      else if (o !== e)
        $display("FAIL flags_result%0d: got code=%0d min=%0d max=%0d b=%0b s=%0b o=%0b want code=%0d min=%0d max=%0d b=%0b s=%0b o=%0b",
                 r, o.code, o.mn, o.mx, o.bub, o.sat, o.ovr, e.code, e.mn, e.mx, e.bub, e.sat, e.ovr);
      else n_pass++;
    end
  endtask

  task automatic test_overrun();
    res_t o, e;
    bit   ok;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h0000_003F, 1'b1);
    wait_valid();
    for (int i = 0; i < 4; i++) send(32'h0000_0001, 1'b0);
    // Result must stay put while the dropped codes flow through.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL hold_stable%0d: no expected result queued", i);
      else if (out_valid !== 1'b1 || {out_code, out_min, out_max, out_bubble, out_sat, out_overrun} !== exp_q[0])
        $display("FAIL hold_stable%0d: got valid=%0b code=%0d min=%0d max=%0d want valid=1 code=%0d min=%0d max=%0d",
                 i, out_valid, out_code, out_min, out_max, exp_q[0].code, exp_q[0].mn, exp_q[0].mx);
      else n_pass++;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    take_result(o, e, ok);
    n_checks++;
    if (!ok) $display("FAIL overrun_held: no result within budget");
    else if (o !== e)
      $display("FAIL overrun_held: got code=%0d min=%0d max=%0d o=%0b want code=%0d min=%0d max=%0d o=%0b",
               o.code, o.mn, o.mx, o.ovr, e.code, e.mn, e.mx, e.ovr);
    else n_pass++;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 4; i++) send((w == 0) ? 32'h0000_0003 : 32'h0000_0007, 1'b1);
      take_result(o, e, ok);
      n_checks++;
      if (!ok) $display("FAIL overrun_next%0d: no result within budget", w);
      else if (o !== e)
        $display("FAIL overrun_next%0d: got code=%0d min=%0d max=%0d o=%0b want code=%0d min=%0d max=%0d o=%0b",
                 w, o.code, o.mn, o.mx, o.ovr, e.code, e.mn, e.mx, e.ovr);
      else n_pass++;
    end
  endtask

  // Handshake lands on the same edge as a stage-2 code; that code opens the next window.
  task automatic test_coincide();
    res_t o, e;
    bit   ok;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h0000_00FF, 1'b1);
    wait_valid();
    send(32'h0000_3FFF, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(32'h0000_000F, 1'b1);
    for (int r = 0; r < 2; r++) begin
      take_result(o, e, ok);
      n_checks++;
      if (!ok) $display("FAIL coincide_result%0d: no result within budget", r);
      else if (o !== e)
        $display("FAIL coincide_result%0d: got code=%0d min=%0d max=%0d o=%0b want code=%0d min=%0d max=%0d o=%0b",
                 r, o.code, o.mn, o.mx, o.ovr, e.code, e.mn, e.mx, e.ovr);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    res_t o, e;
    bit   ok;
    out_ready = 1'b1;
    send(32'h00FF_FFFF, 1'b1);
    send(32'h00FF_FFFF, 1'b1);
    #3;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, out_code, out_min, out_max, out_bubble, out_sat, out_overrun} !== '0)
      $display("FAIL reset_async: got valid=%0b code=%0d min=%0d max=%0d flags=%b want all 0",
               out_valid, out_code, out_min, out_max, {out_bubble, out_sat, out_overrun});
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, out_code, out_min, out_max, out_bubble, out_sat, out_overrun} !== '0)
      $display("FAIL reset_held: got valid=%0b code=%0d min=%0d max=%0d want all 0",
               out_valid, out_code, out_min, out_max);
    else n_pass++;
    model_clear();
    m_pend = 1'b0;
    exp_q.delete();
    obs_q.delete();
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(32'h0000_FFFF, 1'b1);
    take_result(o, e, ok);
    n_checks++;
    if (!ok) $display("FAIL reset_after: no result within budget");
    else if (o !== e)
      $display("FAIL reset_after: got code=%0d min=%0d max=%0d want code=%0d min=%0d max=%0d",
               o.code, o.mn, o.mx, e.code, e.mn, e.mx);
    else n_pass++;
  endtask

  initial begin
    model_clear();
    m_pend = 1'b0;
    test_reset();
    test_defaults();
    test_ramp();
    test_back_to_back_flags();
    test_overrun();
    test_coincide();
    test_reset_mid();
    repeat (5) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0)
      $display("FAIL leftovers: got exp=%0d obs=%0d want 0/0", exp_q.size(), obs_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
